// File: rtl/aes_gcm_ctr_gen.sv
// -----------------------------------------------------------------------------
// aes_gcm_ctr_gen
// GCM counter-block generator. On an accepted start it forms J0 = IV || 1 and
// pulses it once on a side port for tag generation. It then streams inc32
// counter blocks IV||2, IV||3, ... to the AES data path under valid/ready.
//
// Optional feature: define AES_GCM_CTR_WRAP_ERR_EN to stop a request with a
// sticky o_wrap_err when the low counter word would wrap past all-ones.
// Without the macro the wrap is silent and o_wrap_err stays 0.
//
// Ports
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   i_start, i_iv,        start request (IDLE only), IV and block count
//   i_num_blk             sampled on an accepted start
//   i_abort               synchronous flush to IDLE, wins over everything
//   o_j0, o_j0_vld        J0 value (held) and its one-cycle valid pulse
//   o_ctr_blk, o_ctr_vld, counter block stream; i_ctr_rdy completes a
//   i_ctr_rdy, o_ctr_last transfer, o_ctr_last marks the final block
//   o_busy, o_done        request in flight / one-cycle completion pulse
//   o_wrap_err            sticky counter-wrap flag
// -----------------------------------------------------------------------------
module aes_gcm_ctr_gen #(
   parameter int RND_SIZE = 128,
   parameter int IV_SIZE  = 96,
   parameter int CTR_SIZE = 32,
   parameter int LEN_SIZE = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_start,
   input  logic [IV_SIZE-1:0]  i_iv,
   input  logic [LEN_SIZE-1:0] i_num_blk,
   input  logic                i_abort,
   output logic [RND_SIZE-1:0] o_j0,
   output logic                o_j0_vld,
   output logic [RND_SIZE-1:0] o_ctr_blk,
   output logic                o_ctr_vld,
   input  logic                i_ctr_rdy,
   output logic                o_ctr_last,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_wrap_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_J0   = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                state_q,    state_d;
   logic [IV_SIZE-1:0]    iv_q,       iv_d;
   logic [CTR_SIZE-1:0]   ctr_q,      ctr_d;
   logic [LEN_SIZE-1:0]   rem_q,      rem_d;
   logic [RND_SIZE-1:0]   j0_q,       j0_d;
   logic                  wrap_q,     wrap_d;
   logic                  j0_vld_q,   ctr_vld_q, last_q, busy_q, done_q;
   logic                  xfer_s;
   logic                  wrap_hit_s;

   assign xfer_s = (state_q == ST_RUN) && i_ctr_rdy;

`ifdef AES_GCM_CTR_WRAP_ERR_EN
   // A non-final transfer of the all-ones low word would expose a wrapped block.
   assign wrap_hit_s = (ctr_q == {CTR_SIZE{1'b1}});
`else
   assign wrap_hit_s = 1'b0;
`endif

   // Next-state and datapath update logic.
   always_comb begin
      state_d = state_q;
      iv_d    = iv_q;
      ctr_d   = ctr_q;
      rem_d   = rem_q;
      j0_d    = j0_q;
      wrap_d  = wrap_q;
      case (state_q)
         ST_IDLE: begin
            if (i_abort) begin
               state_d = ST_IDLE;
            end else if (i_start) begin
               state_d = ST_J0;
               iv_d    = i_iv;
               rem_d   = i_num_blk;
               ctr_d   = CTR_SIZE'(2);
               j0_d    = {i_iv, CTR_SIZE'(1)};
               wrap_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_J0: begin
            if (i_abort) begin
               state_d = ST_IDLE;
            end else if (rem_q == {LEN_SIZE{1'b0}}) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (i_abort) begin
               state_d = ST_IDLE;
            end else if (xfer_s) begin
               // Only the low word counts; no carry into the IV bits.
               rem_d = rem_q - LEN_SIZE'(1);
               ctr_d = ctr_q + CTR_SIZE'(1);
               if (rem_q == LEN_SIZE'(1)) begin
                  state_d = ST_DONE;
               end else if (wrap_hit_s) begin
                  state_d = ST_DONE;
                  wrap_d  = 1'b1;
               end else begin
                  state_d = ST_RUN;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         iv_q      <= {IV_SIZE{1'b0}};
         ctr_q     <= {CTR_SIZE{1'b0}};
         rem_q     <= {LEN_SIZE{1'b0}};
         j0_q      <= {RND_SIZE{1'b0}};
         wrap_q    <= 1'b0;
         j0_vld_q  <= 1'b0;
         ctr_vld_q <= 1'b0;
         last_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         iv_q      <= iv_d;
         ctr_q     <= ctr_d;
         rem_q     <= rem_d;
         j0_q      <= j0_d;
         wrap_q    <= wrap_d;
         j0_vld_q  <= (state_d == ST_J0);
         ctr_vld_q <= (state_d == ST_RUN);
         last_q    <= (state_d == ST_RUN) && (rem_d == LEN_SIZE'(1));
         busy_q    <= (state_d != ST_IDLE);
         done_q    <= (state_d == ST_DONE);
      end
   end

   assign o_j0       = j0_q;
   assign o_j0_vld   = j0_vld_q;
   assign o_ctr_blk  = {iv_q, ctr_q};
   assign o_ctr_vld  = ctr_vld_q;
   assign o_ctr_last = last_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_wrap_err = wrap_q;

endmodule

// File: tb/tb_aes_gcm_ctr_gen.sv
// -----------------------------------------------------------------------------
// tb_aes_gcm_ctr_gen
// Directed and randomized checks of the GCM counter-block generator. The
// expected block for the k-th transfer of a request is simply IV || (k+2).
// A second instance with a 2-bit counter reaches the all-ones low word in a
// few blocks so the wrap behaviour can be observed.
// -----------------------------------------------------------------------------
module tb_aes_gcm_ctr_gen;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, abort = 1'b0, rdy = 1'b0;
   logic [95:0]   iv = '0;
   logic [31:0]   nblk = '0;
   logic [127:0]  j0, blk;
   logic          j0_vld, vld, last, busy, done, werr;

   logic          w_start = 1'b0, w_rdy = 1'b0;
   logic          w_abort = 1'b0;
   logic [125:0]  w_iv = '0;
   logic [31:0]   w_nblk = '0;
   logic [127:0]  w_j0, w_blk;
   logic          w_j0_vld, w_vld, w_last, w_busy, w_done, w_werr;

   int n_err = 0;
   int n_checks = 0;

   always #5 clk = ~clk;

   aes_gcm_ctr_gen dut (
      .clk(clk), .rst_n(rst_n), .i_start(start), .i_iv(iv), .i_num_blk(nblk),
      .i_abort(abort), .o_j0(j0), .o_j0_vld(j0_vld), .o_ctr_blk(blk),
      .o_ctr_vld(vld), .i_ctr_rdy(rdy), .o_ctr_last(last), .o_busy(busy),
      .o_done(done), .o_wrap_err(werr)
   );

   aes_gcm_ctr_gen #(.RND_SIZE(128), .IV_SIZE(126), .CTR_SIZE(2), .LEN_SIZE(32)) dut_w (
      .clk(clk), .rst_n(rst_n), .i_start(w_start), .i_iv(w_iv), .i_num_blk(w_nblk),
      .i_abort(w_abort), .o_j0(w_j0), .o_j0_vld(w_j0_vld), .o_ctr_blk(w_blk),
      .o_ctr_vld(w_vld), .i_ctr_rdy(w_rdy), .o_ctr_last(w_last), .o_busy(w_busy),
      .o_done(w_done), .o_wrap_err(w_werr)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [95:0] rand_iv();
      return {$urandom, $urandom, $urandom};
   endfunction

   // One request on the main instance. abort_k = index of the block during
   // which i_abort is raised (with rdy=1); out of range means no abort.
   task automatic run_req(input logic [95:0] riv, input logic [31:0] n,
                          input bit use_pat, input logic [15:0] pat, input int abort_k);
      int k = 0;
      int cyc = 0;
      logic r;
      start = 1'b1; iv = riv; nblk = n;
      tick();
      start = 1'b0; iv = rand_iv(); nblk = $urandom;
      chk("j0_vld", j0_vld, 1'b1);
      chk("j0", j0, {riv, 32'h1});
      chk("busy_j0", busy, 1'b1);
      chk("vld_j0", vld, 1'b0);
      tick();
      while (k < int'(n)) begin
         if (cyc >= 200) begin
            n_checks++;
            n_err++;
            $error("FAIL run_budget observed=%0d transfers expected=%0d", k, n);
            break;
         end
         chk("vld", vld, 1'b1);
         chk("blk", blk, {riv, 32'(k + 2)});
         chk("last", last, (k == int'(n) - 1));
         chk("done_run", done, 1'b0);
         start = 1'($urandom_range(0, 1));
         iv = rand_iv();
         if (k == abort_k) begin
            abort = 1'b1; rdy = 1'b1;
            tick();
            abort = 1'b0; rdy = 1'b0; start = 1'b0;
            chk("abort_busy", busy, 1'b0);
            chk("abort_vld", vld, 1'b0);
            chk("abort_done", done, 1'b0);
            chk("abort_j0_kept", j0, {riv, 32'h1});
            return;
         end
         r = use_pat ? ((cyc < 16) ? pat[cyc] : 1'b1) : 1'($urandom_range(0, 1));
         rdy = r;
         tick();
         cyc++;
         if (r) k++;
      end
      if (use_pat && pat == 16'hFFFF) chk("full_rate_cycles", 32'(cyc), n);
      rdy = 1'b0;
      chk("done", done, 1'b1);
      chk("vld_done", vld, 1'b0);
      chk("busy_done", busy, 1'b1);
      chk("werr_main", werr, 1'b0);
      start = 1'b1;                       // must be ignored in DONE
      tick();
      start = 1'b0;
      chk("done_clear", done, 1'b0);
      chk("busy_idle", busy, 1'b0);
      chk("no_restart", j0_vld, 1'b0);
   endtask

   initial begin
      logic [95:0]  civ;
      logic [125:0] wiv;

      // Reset state.
      tick(); tick();
      chk("rst_blk", blk, 128'h0);
      chk("rst_j0", j0, 128'h0);
      chk("rst_flags", {j0_vld, vld, last, busy, done, werr}, 6'b0);
      @(negedge clk); rst_n = 1'b1;
      tick();
      chk("idle_busy", busy, 1'b0);

      // Directed: full rate, ready pattern, zero blocks.
      civ = 96'hCAFEBABE_FACEDBAD_DECAF888;
      run_req(civ, 32'd3, 1'b1, 16'hFFFF, -1);
      run_req(civ, 32'd3, 1'b1, 16'hFFE9, -1);
      run_req(civ, 32'd0, 1'b1, 16'hFFFF, -1);

      // Abort during the second block, then a one-block request.
      run_req(civ, 32'd3, 1'b1, 16'hFFFF, 1);
      run_req(96'h0123_4567_89AB_CDEF_0F1E_2D3C, 32'd1, 1'b1, 16'hFFFF, -1);

      // Abort wins over start in IDLE.
      start = 1'b1; abort = 1'b1; iv = rand_iv(); nblk = 32'd2;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("abort_idle_j0vld", j0_vld, 1'b0);
      chk("abort_idle_busy", busy, 1'b0);

      // Randomized requests.
      for (int i = 0; i < 10; i++) begin
         run_req(rand_iv(), 32'($urandom_range(0, 5)), 1'b0, 16'h0, $urandom_range(0, 9));
      end

      // Reset asserted mid-request.
      start = 1'b1; iv = rand_iv(); nblk = 32'd10; rdy = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      chk("pre_rst_vld", vld, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_blk", blk, 128'h0);
      chk("mid_rst_j0", j0, 128'h0);
      chk("mid_rst_flags", {j0_vld, vld, last, busy, done, werr}, 6'b0);
      @(negedge clk); rst_n = 1'b1; rdy = 1'b0;
      tick(); tick();
      chk("post_rst_busy", busy, 1'b0);
      chk("post_rst_done", done, 1'b0);

      // Counter wrap on the 2-bit-counter instance: blocks run 2, 3(all ones), ...
      wiv = {$urandom, $urandom, $urandom, 30'($urandom)};
      w_start = 1'b1; w_iv = wiv; w_nblk = 32'd4; w_rdy = 1'b1;
      tick();
      w_start = 1'b0;
      chk("w_j0", w_j0, {wiv, 2'b01});
      tick();
`ifdef AES_GCM_CTR_WRAP_ERR_EN
      for (int i = 0; i < 2; i++) begin
         chk("w_blk", w_blk, {wiv, 2'(i + 2)});
         chk("w_last", w_last, 1'b0);
         tick();
      end
      chk("w_done", w_done, 1'b1);
      chk("w_vld_stop", w_vld, 1'b0);
      chk("w_werr_set", w_werr, 1'b1);
      tick();
      chk("w_werr_sticky", w_werr, 1'b1);
`else
      for (int i = 0; i < 4; i++) begin
         chk("w_blk", w_blk, {wiv, 2'(i + 2)});
         chk("w_last", w_last, (i == 3));
         chk("w_werr", w_werr, 1'b0);
         tick();
      end
      chk("w_done", w_done, 1'b1);
      tick();
`endif
      // A new accepted start clears the wrap flag.
      w_start = 1'b1; w_nblk = 32'd0;
      tick();
      w_start = 1'b0; w_rdy = 1'b0;
      chk("w_werr_clear", w_werr, 1'b0);
      tick();
      chk("w_done0", w_done, 1'b1);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
